// File: rtl/cpu_log_checker.sv
// Character-serial checker for CPU trace lines "^time@pc: *addr <= data#" and
// "^time@pc: $grf <= data#"; flags timing, pc, addr and register violations.
module cpu_log_checker #(
    parameter int          HEX_DIGITS  = 8,
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter logic [31:0] PC_LO       = 32'h3000,
    parameter logic [31:0] PC_HI       = 32'h4fff,
    parameter logic [31:0] ADDR_HI     = 32'h2fff,
    parameter int          NREG        = 32,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic [1:0]       format_type,
    output logic [3:0]       error_code,
    output logic             line_done,
    output logic [CNT_W-1:0] ok_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [3:0] {
        IDLE, CARET, TIME, AT, PC, COLON, STAR, ADDR,
        DOLLAR, GRF, SP1, LT, EQ, DATA, DONE_MEM, DONE_REG
    } state_t;

    localparam logic [7:0]  HEX_N  = 8'(HEX_DIGITS);
    localparam logic [7:0]  TIME_N = 8'(TIME_DIGITS);
    localparam logic [7:0]  GRF_N  = 8'(GRF_DIGITS);
    localparam logic [31:0] NREG_W = 32'(NREG);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] time_q, time_d, pc_q, pc_d, addr_q, addr_d;
    logic [31:0] grf_q, grf_d, data_q, data_d;
    logic        is_mem_q, is_mem_d;
    logic        is_dec, is_hex;
    logic [31:0] digit;
    logic [31:0] time_mask;
    logic [3:0]  err_d;
    logic        done_d;

    always_comb begin
        is_dec = (char >= "0") && (char <= "9");
        is_hex = is_dec || ((char >= "a") && (char <= "f"));
        digit  = is_dec ? {28'd0, 4'(char - 8'h30)} : {28'd0, 4'(char - 8'h57)};
    end

    // cnt tracks digits taken by the field currently being accumulated
    always_comb begin
        state_d  = IDLE;
        cnt_d    = cnt_q;
        time_d   = time_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        grf_d    = grf_q;
        data_d   = data_q;
        is_mem_d = is_mem_q;
        if (char == "^") begin
            state_d = CARET;
            cnt_d   = 8'd0;
            time_d  = 32'd0;
            pc_d    = 32'd0;
            addr_d  = 32'd0;
            grf_d   = 32'd0;
            data_d  = 32'd0;
        end else begin
            case (state_q)
                CARET: if (is_dec) begin
                    state_d = TIME; cnt_d = 8'd1; time_d = digit;
                end
                TIME: if (is_dec && cnt_q < TIME_N) begin
                    state_d = TIME; cnt_d = cnt_q + 8'd1; time_d = time_q * 32'd10 + digit;
                end else if (char == "@") state_d = AT;
                AT: if (is_hex) begin
                    state_d = PC; cnt_d = 8'd1; pc_d = (pc_q << 4) | digit;
                end
                PC: if (is_hex && cnt_q < HEX_N) begin
                    state_d = PC; cnt_d = cnt_q + 8'd1; pc_d = (pc_q << 4) | digit;
                end else if (char == ":" && cnt_q == HEX_N) state_d = COLON;
                COLON: if (char == " ") state_d = COLON;
                else if (char == "*") begin state_d = STAR; is_mem_d = 1'b1; end
                else if (char == "$") begin state_d = DOLLAR; is_mem_d = 1'b0; end
                STAR: if (is_hex) begin
                    state_d = ADDR; cnt_d = 8'd1; addr_d = (addr_q << 4) | digit;
                end
                ADDR: if (is_hex && cnt_q < HEX_N) begin
                    state_d = ADDR; cnt_d = cnt_q + 8'd1; addr_d = (addr_q << 4) | digit;
                end else if (cnt_q == HEX_N && char == " ") state_d = SP1;
                else if (cnt_q == HEX_N && char == "<") state_d = LT;
                DOLLAR: if (is_dec) begin
                    state_d = GRF; cnt_d = 8'd1; grf_d = digit;
                end
                GRF: if (is_dec && cnt_q < GRF_N) begin
                    state_d = GRF; cnt_d = cnt_q + 8'd1; grf_d = grf_q * 32'd10 + digit;
                end else if (char == " ") state_d = SP1;
                else if (char == "<") state_d = LT;
                SP1: if (char == " ") state_d = SP1;
                else if (char == "<") state_d = LT;
                LT: if (char == "=") state_d = EQ;
                EQ: if (char == " ") state_d = EQ;
                else if (is_hex) begin
                    state_d = DATA; cnt_d = 8'd1; data_d = (data_q << 4) | digit;
                end
                DATA: if (is_hex && cnt_q < HEX_N) begin
                    state_d = DATA; cnt_d = cnt_q + 8'd1; data_d = (data_q << 4) | digit;
                end else if (char == "#" && cnt_q == HEX_N)
                    state_d = is_mem_q ? DONE_MEM : DONE_REG;
                default: state_d = IDLE;
            endcase
        end
    end

    // Checks use the accumulators as they stand when '#' is sampled
    always_comb begin
        time_mask = {16'h0000, (freq >> 1) - 16'd1};
        err_d[0]  = (time_q & time_mask) != 32'd0;
        err_d[1]  = (pc_q < PC_LO) || (pc_q > PC_HI) || (pc_q[1:0] != 2'b00);
        err_d[2]  = is_mem_q && ((addr_q > ADDR_HI) || (addr_q[1:0] != 2'b00));
        err_d[3]  = !is_mem_q && (grf_q >= NREG_W);
        done_d    = (state_d == DONE_MEM) || (state_d == DONE_REG);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            time_q      <= 32'd0;
            pc_q        <= 32'd0;
            addr_q      <= 32'd0;
            grf_q       <= 32'd0;
            data_q      <= 32'd0;
            is_mem_q    <= 1'b0;
            format_type <= 2'b00;
            error_code  <= 4'b0000;
            line_done   <= 1'b0;
            ok_count    <= '0;
            err_count   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            time_q      <= time_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            grf_q       <= grf_d;
            data_q      <= data_d;
            is_mem_q    <= is_mem_d;
            line_done   <= done_d;
            format_type <= (state_d == DONE_MEM) ? 2'b10 :
                           (state_d == DONE_REG) ? 2'b01 : 2'b00;
            error_code  <= done_d ? err_d : 4'b0000;
            if (done_d && err_d == 4'b0000 && ok_count != {CNT_W{1'b1}})
                ok_count <= ok_count + 1'b1;
            if (done_d && err_d != 4'b0000 && err_count != {CNT_W{1'b1}})
                err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: doc/cpu_log_checker.md
CPU_LOG_CHECKER -- requirements
Module: cpu_log_checker

Interface
REQ-001 Parameter HEX_DIGITS, default 8: exact hex digit count of the pc, addr and data fields.
REQ-002 Parameter TIME_DIGITS, default 4: maximum decimal digit count of the time field.
REQ-003 Parameter GRF_DIGITS, default 4: maximum decimal digit count of the register field.
REQ-004 Parameter PC_LO/PC_HI, default 32'h3000/32'h4fff: inclusive legal pc range.
REQ-005 Parameter ADDR_HI, default 32'h2fff: inclusive upper bound of the legal addr (lower bound 0).
REQ-006 Parameter NREG, default 32: number of legal registers (0..NREG-1).
REQ-007 Parameter CNT_W, default 16: width of the line counters.
REQ-008 clk  input  1  sole clock; all state changes on the rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 char  input  8  ASCII character sampled every rising edge.
REQ-011 freq  input  16  time-check period; a power of two >= 2.
REQ-012 format_type  output  2  01 = register line, 10 = memory line, 00 = none.
REQ-013 error_code  output  4  bit0 time, bit1 pc, bit2 addr, bit3 grf.
REQ-014 line_done  output  1  one-cycle pulse marking a completed legal line.
REQ-015 ok_count  output  CNT_W  count of completed lines with error_code 0.
REQ-016 err_count  output  CNT_W  count of completed lines with nonzero error_code.

Function
REQ-017 Memory grammar: '^' time '@' pc ':' ' '* '*' addr ' '* "<=" ' '* data '#'.
REQ-018 Register grammar: '^' time '@' pc ':' ' '* '$' grf ' '* "<=" ' '* data '#'.
REQ-019 time and grf are 1..TIME_DIGITS / 1..GRF_DIGITS decimal digits; pc, addr and data are exactly HEX_DIGITS lowercase hex digits [0-9a-f].
REQ-020 FSM states: IDLE, CARET, TIME, AT, PC, COLON, STAR, ADDR, DOLLAR, GRF, SP1, LT, EQ, DATA, DONE_MEM, DONE_REG; each space run is absorbed by the state that precedes it.
REQ-021 Any character not legal in the current state sends the FSM to IDLE; '^' sends it from any state to CARET, which also clears all field accumulators.
REQ-022 A digit that exceeds a field's maximum length sends the FSM to IDLE; for hex fields, a non-digit arriving before HEX_DIGITS digits sends it to IDLE.
REQ-023 Accumulators: time and grf = acc*10 + digit; pc, addr and data = {acc[27:0], nibble}; all are 32 bits wide.
REQ-024 In the cycle after the edge that samples '#', state = DONE_x, format_type is driven, error_code is driven and line_done = 1; all three are registered and last exactly one cycle.
REQ-025 error_code[0] = 1 iff (time & (freq/2 - 1)) != 0.
REQ-026 error_code[1] = 1 iff pc < PC_LO, pc > PC_HI, or pc[1:0] != 0.
REQ-027 error_code[2] = 1 iff addr > ADDR_HI or addr[1:0] != 0; it is evaluated on memory lines only and is 0 on register lines.
REQ-028 error_code[3] = 1 iff grf >= NREG; it is evaluated on register lines only and is 0 on memory lines.
REQ-029 Outside DONE_x cycles: format_type = 00, error_code = 0, line_done = 0.
REQ-030 ok_count or err_count increments by 1 in the same edge that enters DONE_x; both counters saturate at all-ones.
REQ-031 A '^' sampled in DONE_x starts a new line with no idle gap, so back-to-back lines are legal.
REQ-032 The '#' state accepts only the character '#'; any other character after the data field goes to IDLE with no report.

Reset
REQ-033 While reset = 0: state = IDLE, all accumulators 0, format_type = 00, error_code = 0, line_done = 0, ok_count = 0, err_count = 0; reset takes effect immediately, without waiting for a clock edge.
REQ-034 Asserting reset mid-line discards the line; after release, only a fresh '^' starts parsing.

Verification
REQ-035 "^10@00003010: *00000000 <= 0000abcd#", freq=4 -> format_type=10, error_code=0000, line_done=1 for one cycle, ok_count=1.
REQ-036 "^3@00003001: $35 <= 12345678#", freq=4 -> format_type=01, error_code=1011 (time, pc misaligned, grf), err_count=1.
REQ-037 "^12@0000300:..." (7-digit pc), then "^^1@00003000:   *00003000<=   00000000#", freq=2 -> first line gives no report; second line error_code=0100 (addr), count +1.
REQ-038 "^12345@..." with TIME_DIGITS=4 -> no report; a following legal line parses correctly.
REQ-039 reset pulsed low mid-addr, then a legal line -> no stale report; ok_count goes 0 -> 1.
REQ-040 CNT_W=2, five legal lines -> ok_count saturates at 3.
